// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: sequencer state
// encoding, instruction field layout and the control unit's opcode map.
package instr_fetch_unit_pkg;

  // Sequencer states, binary encoded; also visible on the debug port.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Instruction field bit positions.
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RA_MSB = 11;
  localparam int RA_LSB = 8;
  localparam int RB_MSB = 7;
  localparam int RB_LSB = 4;
  localparam int RC_MSB = 3;
  localparam int RC_LSB = 0;

  // Control unit opcode map; only OP_HALT is interpreted by the fetch unit.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Decoded instruction fields; imm8 is {rb, rc}.
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
  } instr_t;

  // Split a raw instruction word into its fields.
  function automatic instr_t decode(input logic [15:0] word);
    instr_t f;
    f.op = word[OP_MSB:OP_LSB];
    f.ra = word[RA_MSB:RA_LSB];
    f.rb = word[RB_MSB:RB_LSB];
    f.rc = word[RC_MSB:RC_LSB];
    return f;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_ack_timer.sv
// Counts consecutive FETCH cycles without an acknowledge. expired is high
// in the cycle whose increment would bring the count up to LIMIT.
module ack_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  // Flag the increment that reaches the limit.
  assign expired = inc && !clear && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-side sequencer: fetches a word over req/ack, issues it to
// the control unit for one cycle, waits for exec_done, then advances or
// branches the PC.
//
// Memory handshake: imem_req rises with entry to FETCH and stays high until
// the cycle in which imem_ack is sampled high; imem_rdata is captured in that
// same cycle. imem_ack is ignored whenever the unit is not in FETCH.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OP     = OP_HALT,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [3:0]  op,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  rc,
  output logic        ctrl_en,
  input  logic        exec_done,
  input  logic        pc_sel,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  state_t      state;
  logic [15:0] ir;
  instr_t      fields;
  logic        timer_clear;
  logic        timer_inc;
  logic        timer_expired;

  // Fields come straight from the latched word, so they hold until the next ack.
  assign fields    = decode(ir);
  assign op        = fields.op;
  assign ra        = fields.ra;
  assign rb        = fields.rb;
  assign rc        = fields.rc;
  assign imem_addr = pc;
  assign state_dbg = state;

  // The timer only runs while waiting on memory; any ack restarts it.
  assign timer_clear = (state != S_FETCH) || imem_ack;
  assign timer_inc   = (state == S_FETCH) && !imem_ack;

  ack_timer #(
    .W     (8),
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // Sequencer with registered req/issue/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
      ctrl_en  <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      ctrl_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          // An ack in the timeout cycle still counts as a good fetch.
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            ctrl_en  <= (imem_rdata[OP_MSB:OP_LSB] != HALT_OP);
            state    <= S_ISSUE;
          end else if (timer_expired) begin
            fault    <= 1'b1;
            imem_req <= 1'b0;
            state    <= S_FAULT;
          end
        end
        S_ISSUE: begin
          if (op == HALT_OP) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // run is only consulted once the current instruction completes.
          if (exec_done) begin
            pc <= pc_sel ? branch_target : pc + 16'd1;
            if (run) begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALTED, S_FAULT: begin
          imem_req <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
